// File: rtl/barrett_precompute_if.sv
// Request/result bundle for barrett_precompute.
//   iStart : request to compute Barrett parameters for iMod (master -> slave)
//   iMod   : W-bit modulus, sampled only on the accepting edge
//   oBusy  : computation in flight (LOAD, DIV or FIN)
//   oDone  : one-cycle completion pulse
//   oErr   : illegal modulus (m < 2), valid with oDone
//   oK     : bit length of the modulus
//   oU     : floor(2^(2k)/m), 2W bits
interface barrett_precompute_if #(
    parameter int W = 64
);
    localparam int KW = $clog2(W + 1);

    logic            iStart;
    logic [W-1:0]    iMod;
    logic            oBusy;
    logic            oDone;
    logic            oErr;
    logic [KW-1:0]   oK;
    logic [2*W-1:0]  oU;

    modport master (output iStart, iMod, input  oBusy, oDone, oErr, oK, oU);
    modport slave  (input  iStart, iMod, output oBusy, oDone, oErr, oK, oU);
endinterface

// File: rtl/barrett_precompute.sv
// Computes the Barrett reduction constants for a modulus m:
//   k = bit length of m, u = floor(2^(2k)/m)
// using a bit-serial restoring divider (one quotient bit per clock).
// Ports:
//   iClk : clock, rising edge
//   iRst : synchronous, active-high reset
//   bus  : slave side of barrett_precompute_if (start/modulus in, busy/done/err/k/u out)
// Results are registered in FIN and held until the next FIN or reset.
module barrett_precompute #(
    parameter int W = 64
) (
    input  logic                 iClk,
    input  logic                 iRst,
    barrett_precompute_if.slave  bus
);
    localparam int KW = $clog2(W + 1);      // holds k in 1..W
    localparam int CW = $clog2(2 * W + 1);  // holds bit index 0..2W

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_FIN} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    m_q, m_d;
    logic [KW-1:0]   k_q, k_d;
    logic            err_q, err_d;
    logic [W:0]      rem_q, rem_d;
    // Quotient bit 2W is provably 0 for m >= 2, so it is shifted out the top
    // instead of being stored.
    logic [2*W-1:0]  quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   ok_q, ok_d;
    logic [2*W-1:0]  ou_q, ou_d;
    logic            oerr_q, oerr_d;
    logic            done_q, done_d;

    logic [KW-1:0]   k_enc;
    logic [CW-1:0]   two_k;
    logic            div_bit;
    logic [W+1:0]    trial;
    logic [W+1:0]    m_ext;
    logic            fits;

    // Priority encoder: position of the highest set bit, plus one.
    always_comb begin
        k_enc = '0;
        for (int i = 0; i < W; i++) begin
            if (m_q[i]) k_enc = KW'(i + 1);
        end
    end

    // The dividend 2^(2k) has exactly one set bit; the counter walks the bit
    // index from 2W down to 0, so the dividend bit is a single compare.
    assign two_k   = CW'({k_q, 1'b0});
    assign div_bit = (cnt_q == two_k);
    assign trial   = {rem_q, div_bit};
    assign m_ext   = {2'b00, m_q};
    assign fits    = (trial >= m_ext);

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        k_d     = k_q;
        err_d   = err_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        ou_d    = ou_q;
        oerr_d  = oerr_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.iStart) begin
                    m_d     = bus.iMod;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                k_d = k_enc;
                if (m_q < W'(2)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    err_d   = 1'b0;
                    cnt_d   = CW'(2 * W);
                    rem_d   = '0;
                    quo_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // Restoring division step: subtract only if the trial fits.
                rem_d = (W + 1)'(fits ? (trial - m_ext) : trial);
                quo_d = {quo_q[2*W-2:0], fits};
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIN: begin
                ok_d    = err_q ? '0 : k_q;
                ou_d    = err_q ? '0 : quo_q;
                oerr_d  = err_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            ok_q    <= '0;
            ou_q    <= '0;
            oerr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            k_q     <= k_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            ou_q    <= ou_d;
            oerr_q  <= oerr_d;
            done_q  <= done_d;
        end
    end

    assign bus.oBusy = (state_q != S_IDLE);
    assign bus.oDone = done_q;
    assign bus.oErr  = oerr_q;
    assign bus.oK    = ok_q;
    assign bus.oU    = ou_q;
endmodule
